tmds_encoder: RTL and testbench
===============================

# tmds_encoder

Three-channel DVI/HDMI TMDS encoder sitting directly downstream of the HDMI timing/pattern controller. Consumes the parallel video stream (de, hsync, vsync, 24-bit RGB) on the pixel clock. Produces one 10-bit TMDS symbol per channel per cycle for the serializer. Each channel holds DC balance through a running-disparity counter.

## Interface
- Parameters: none.
- rst_i  in  1  reset; asynchronous, active-high
- clk_i  in  1  pixel clock; all I/O synchronous to it
- de_i  in  1  data enable; 1 = active pixel, 0 = blanking
- hsync_i  in  1  horizontal sync, passed as-is (no polarity change)
- vsync_i  in  1  vertical sync, passed as-is
- data_i  in  24  pixel: [23:16] R, [15:8] G, [7:0] B; don't-care while de_i=0
- tmds_ch0_o  out  10  blue channel symbol; carries C0=hsync, C1=vsync during blanking
- tmds_ch1_o  out  10  green channel symbol; C1,C0 = 00 during blanking
- tmds_ch2_o  out  10  red channel symbol; C1,C0 = 00 during blanking
- Symbol bit [0] is transmitted first by the serializer.

## Operation
- Three identical per-channel encoders; only control inputs differ.
- Stage 1 (transition minimisation), registered:
  - N1(D) = ones in D[7:0].
  - XNOR mode if N1(D)>4, or N1(D)==4 and D[0]==0; otherwise XOR mode.
  - q_m[0]=D[0]; q_m[i]=q_m[i-1] op D[i], i=1..7.
  - q_m[8]=0 in XNOR mode, 1 in XOR mode.
  - de, hsync, vsync are registered alongside q_m.
- Stage 2 (DC balance), registered. N1/N0 = ones/zeros in q_m[7:0]. cnt = 5-bit signed disparity per channel.
  - de=1, cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += (q_m[8] ? N1-N0 : N0-N1).
  - de=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - de=1, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1-N0) - 2*(~q_m[8]).
  - de=0: cnt <= 0. out = control symbol for {C1,C0}:
    - 00 -> 10'h354
    - 01 -> 10'h0AB
    - 10 -> 10'h154
    - 11 -> 10'h2AB
- cnt range is always within -8..+8; 5-bit signed arithmetic never overflows. Sign-extend N1/N0 before use.

## Timing
- Fixed latency 2 clk_i cycles: inputs sampled at edge k appear on outputs after edge k+2.
- Throughput one symbol per channel per cycle; no stall, no handshake.
- Reset (asynchronous, any time, including mid-line):
  - All three outputs = 10'h354.
  - All pipeline de/hsync/vsync registers = 0; all cnt = 0.
  - First valid symbol appears 2 cycles after the first edge with rst_i low.
- DE falling edge: first blanking symbol follows the last data symbol with no gap. cnt clears on that same cycle.
- DE rising edge: the first data symbol is encoded with cnt=0.
- hsync/vsync changes during blanking are reflected on ch0 exactly 2 cycles later.

## Test plan
- Reset: assert rst_i asynchronously mid-stream -> all outputs 10'h354 immediately; after release with de=0, hs=vs=0 -> ch0..ch2 = 10'h354.
- Control symbols: de=0, {vs,hs} = 01, 10, 11 -> ch0 = 10'h0AB, 10'h154, 10'h2AB two cycles later. ch1/ch2 stay 10'h354.
- Disparity run: de=1, data_i=24'h000000 for 4 cycles from cnt=0 -> each channel 10'h100, 10'h3FF, 10'h100, 10'h3FF; cnt -8, 2, -6, 4.
- XNOR path: de=1, B=8'hFF from cnt=0 -> ch0 = 10'h200, cnt=-8.
- Balanced word: de=1, B=8'h55 repeated -> ch0 = 10'h133 every cycle; cnt stays 0.
- Blanking clears disparity: after the 8'h00 run, one cycle de=0, then de=1 B=8'h00 -> ch0 = 10'h354, then 10'h100 (cnt restarted at 0). Golden reference model compared over a full frame of random data.

Source files
------------

// File: rtl/tmds_encoder_if.sv
// Parallel video stream into the TMDS encoder and the three 10-bit
// symbols it hands to the serializer. The master drives the pixel stream
// (timing/pattern controller side); the slave is the encoder itself.
interface tmds_encoder_if;
    logic        de_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [23:0] data_i;
    logic [9:0]  tmds_ch0_o;
    logic [9:0]  tmds_ch1_o;
    logic [9:0]  tmds_ch2_o;

    modport master (
        output de_i,
        output hsync_i,
        output vsync_i,
        output data_i,
        input  tmds_ch0_o,
        input  tmds_ch1_o,
        input  tmds_ch2_o
    );

    modport slave (
        input  de_i,
        input  hsync_i,
        input  vsync_i,
        input  data_i,
        output tmds_ch0_o,
        output tmds_ch1_o,
        output tmds_ch2_o
    );
endinterface

// File: rtl/tmds_encoder.sv
// Three-channel DVI/HDMI TMDS encoder. Channel 0 carries blue plus the
// sync controls, channel 1 green, channel 2 red. Two registered stages:
// transition minimisation, then DC balancing with a per-channel running
// disparity. Fixed latency of two pixel clocks, one symbol per cycle.
module tmds_encoder (
    input  logic          clk_i,
    input  logic          rst_i,
    tmds_encoder_if.slave vid
);

    localparam int NUM_CH = 3;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    // Population count of an 8-bit word (0..8).
    function automatic logic [3:0] count_ones(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // Chains XOR or XNOR through the byte, whichever yields fewer
    // transitions; bit 8 records which was used (1 = XOR).
    function automatic logic [8:0] minimise_transitions(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = count_ones(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Blanking-period control token for {C1,C0}.
    function automatic logic [9:0] control_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    // Stage-1 combinational result and pipeline registers.
    logic [8:0]        qm_d  [NUM_CH];
    logic [8:0]        qm_q  [NUM_CH];
    logic              de_q;
    logic              hsync_q;
    logic              vsync_q;

    // Stage-2 combinational result and output/disparity registers.
    logic [9:0]        sym_d [NUM_CH];
    logic [9:0]        sym_q [NUM_CH];
    logic signed [4:0] cnt_d [NUM_CH];
    logic signed [4:0] cnt_q [NUM_CH];

    // Transition-minimised word for each colour byte.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            qm_d[ch] = minimise_transitions(vid.data_i[ch*8 +: 8]);
        end
    end

    // Stage 1 registers: q_m words plus the controls travelling with them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                qm_q[ch] <= '0;
            end
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                qm_q[ch] <= qm_d[ch];
            end
            de_q    <= vid.de_i;
            hsync_q <= vid.hsync_i;
            vsync_q <= vid.vsync_i;
        end
    end

    // DC-balance decision and next running disparity for each channel.
    always_comb begin
        logic [3:0]        ones;
        logic signed [4:0] n1s;
        logic signed [4:0] n0s;
        logic signed [4:0] bal;
        logic signed [4:0] q8_x2;
        logic signed [4:0] nq8_x2;
        logic [1:0]        ctl;
        logic [8:0]        qm;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sym_d[ch] = CTRL_00;
            cnt_d[ch] = '0;
            qm        = qm_q[ch];
            ctl       = (ch == 0) ? {vsync_q, hsync_q} : 2'b00;
            ones      = count_ones(qm[7:0]);
            n1s       = $signed({1'b0, ones});
            n0s       = 5'sd8 - n1s;
            bal       = n1s - n0s;
            q8_x2     = qm[8] ? 5'sd2 : 5'sd0;
            nq8_x2    = qm[8] ? 5'sd0 : 5'sd2;
            if (!de_q) begin
                sym_d[ch] = control_symbol(ctl);
                cnt_d[ch] = '0;
            end else if ((cnt_q[ch] == 5'sd0) || (n1s == n0s)) begin
                sym_d[ch] = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                cnt_d[ch] = cnt_q[ch] + (qm[8] ? bal : -bal);
            end else if (((cnt_q[ch] > 5'sd0) && (n1s > n0s)) ||
                         ((cnt_q[ch] < 5'sd0) && (n0s > n1s))) begin
                sym_d[ch] = {1'b1, qm[8], ~qm[7:0]};
                cnt_d[ch] = cnt_q[ch] + q8_x2 - bal;
            end else begin
                sym_d[ch] = {1'b0, qm[8], qm[7:0]};
                cnt_d[ch] = cnt_q[ch] + bal - nq8_x2;
            end
        end
    end

    // Stage 2 registers: output symbols and running disparity.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sym_q[ch] <= CTRL_00;
                cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sym_q[ch] <= sym_d[ch];
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign vid.tmds_ch0_o = sym_q[0];
    assign vid.tmds_ch1_o = sym_q[1];
    assign vid.tmds_ch2_o = sym_q[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed sequences with known
// symbols, then a randomised frame checked against a behavioural model.
module tb_tmds_encoder;

    logic clk_i;
    logic rst_i;

    tmds_encoder_if vif ();

    tmds_encoder dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vid   (vif)
    );

    // Free-running pixel clock, 10 time units per period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0][9:0] sym;
        logic            has_lit;
        logic [9:0]      lit;
    } expect_t;

    expect_t    exp_q [$];
    int         model_cnt [3];
    int         check_count;
    int         error_count;
    logic [9:0] ctrl_table [4];

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference encoder for one channel, straight from the TMDS rules,
    // using plain integer disparity bookkeeping.
    function automatic logic [9:0] modelSymbol(input int ch, input logic de,
                                              input logic [1:0] ctl, input logic [7:0] d);
        int         ones;
        int         n1;
        int         n0;
        logic       xnor_mode;
        logic       q8;
        logic [7:0] qm;
        logic [9:0] sym;
        if (!de) begin
            model_cnt[ch] = 0;
            return ctrl_table[ctl];
        end
        ones      = $countones(d);
        xnor_mode = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm        = '0;
        qm[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = xnor_mode ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
        end
        q8 = !xnor_mode;
        n1 = $countones(qm);
        n0 = 8 - n1;
        if (model_cnt[ch] == 0 || n1 == n0) begin
            sym = {~q8, q8, (q8 ? qm : ~qm)};
            model_cnt[ch] += q8 ? (n1 - n0) : (n0 - n1);
        end else if ((model_cnt[ch] > 0 && n1 > n0) || (model_cnt[ch] < 0 && n0 > n1)) begin
            sym = {1'b1, q8, ~qm};
            model_cnt[ch] += 2 * int'(q8) + (n0 - n1);
        end else begin
            sym = {1'b0, q8, qm};
            model_cnt[ch] += (n1 - n0) - 2 * int'(!q8);
        end
        return sym;
    endfunction

    // Model state after reset: one reset symbol already in flight.
    task automatic resetModel();
        expect_t e;
        exp_q.delete();
        e.sym     = {10'h354, 10'h354, 10'h354};
        e.has_lit = 1'b0;
        e.lit     = '0;
        exp_q.push_back(e);
        for (int ch = 0; ch < 3; ch++) model_cnt[ch] = 0;
    endtask

    // Drives one pixel at the falling edge, clocks it in, then checks the
    // symbol whose input went in two edges earlier.
    task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                                 input logic [23:0] data, input logic has_lit, input logic [9:0] lit);
        expect_t e;
        vif.de_i    = de;
        vif.hsync_i = hs;
        vif.vsync_i = vs;
        vif.data_i  = data;
        e.sym[0]  = modelSymbol(0, de, {vs, hs}, data[7:0]);
        e.sym[1]  = modelSymbol(1, de, 2'b00, data[15:8]);
        e.sym[2]  = modelSymbol(2, de, 2'b00, data[23:16]);
        e.has_lit = has_lit;
        e.lit     = lit;
        exp_q.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        e = exp_q.pop_front();
        checkOutput("ch0", vif.tmds_ch0_o, e.sym[0]);
        checkOutput("ch1", vif.tmds_ch1_o, e.sym[1]);
        checkOutput("ch2", vif.tmds_ch2_o, e.sym[2]);
        if (e.has_lit) checkOutput("ch0_directed", vif.tmds_ch0_o, e.lit);
    endtask

    // Asserts reset away from any clock edge and checks the outputs at once.
    task automatic asyncReset();
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rst_ch0", vif.tmds_ch0_o, 10'h354);
        checkOutput("rst_ch1", vif.tmds_ch1_o, 10'h354);
        checkOutput("rst_ch2", vif.tmds_ch2_o, 10'h354);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        resetModel();
    endtask

    // Directed sequences, then a randomised frame with a mid-line reset.
    initial begin
        logic hs;
        logic vs;
        check_count   = 0;
        error_count   = 0;
        ctrl_table[0] = 10'h354;
        ctrl_table[1] = 10'h0AB;
        ctrl_table[2] = 10'h154;
        ctrl_table[3] = 10'h2AB;
        rst_i       = 1'b1;
        vif.de_i    = 1'b0;
        vif.hsync_i = 1'b0;
        vif.vsync_i = 1'b0;
        vif.data_i  = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_ch0", vif.tmds_ch0_o, 10'h354);
        checkOutput("reset_ch1", vif.tmds_ch1_o, 10'h354);
        checkOutput("reset_ch2", vif.tmds_ch2_o, 10'h354);
        rst_i = 1'b0;
        resetModel();

        // Control tokens on channel 0.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 10'h354);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h0, 1'b1, 10'h0AB);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0, 1'b1, 10'h154);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'h0, 1'b1, 10'h2AB);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 10'h354);

        // Disparity run on all-zero pixels, then blanking clears it.
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h3FF);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h3FF);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h354);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h100);

        // XNOR path from zero disparity.
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h354);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h0000FF, 1'b1, 10'h200);

        // Balanced word keeps disparity at zero.
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 10'h354);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 24'h555555, 1'b1, 10'h133);

        // Random frame: active runs and blanking with random syncs.
        for (int line = 0; line < 6; line++) begin
            for (int px = 0; px < 48; px++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0, 10'h000);
                if (line == 2 && px == 20) asyncReset();
            end
            for (int b = 0; b < 12; b++) begin
                hs = 1'($urandom_range(0, 1));
                vs = 1'($urandom_range(0, 1));
                applyStimulus(1'b0, hs, vs, 24'($urandom), 1'b0, 10'h000);
            end
        end

        // Drain the pipeline.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 10'h354);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
